// File: rtl/neuron_spike_pkg.sv
// neuron_spike_pkg
//   Shared definitions for the neuron spike scheduler: register word offsets
//   within the control window, CTRL/STATUS bit positions, the FSM state type
//   and the word-count helper used to size the spike-out buffer index.
package neuron_spike_pkg;

  localparam int unsigned WORD_BITS = 32;

  // Word offsets (byte offset >> 2) inside the control window
  localparam logic [5:0] OFF_CTRL      = 6'h00;  // 0x00
  localparam logic [5:0] OFF_STATUS    = 6'h01;  // 0x04
  localparam logic [5:0] OFF_TARGET    = 6'h02;  // 0x08
  localparam logic [5:0] OFF_DONE_CNT  = 6'h03;  // 0x0C
  localparam logic [5:0] OFF_SPIKE_CNT = 6'h04;  // 0x10

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_AUTO   = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;
  localparam int unsigned CTRL_ABORT  = 3;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_COLLECT = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  function automatic int unsigned words_for(input int unsigned neurons);
    return neurons / WORD_BITS;
  endfunction

endpackage

// File: rtl/neuron_spike_scheduler_if.sv
// neuron_spike_scheduler_if
//   Wishbone slave bus bundle for the spike scheduler control window.
//   wbs_cyc_i/stb_i/we_i  cycle, strobe, write enable
//   wbs_sel_i[3:0]        byte lanes
//   wbs_adr_i[31:0]       byte address
//   wbs_dat_i[31:0]       write data
//   wbs_ack_o             one-cycle acknowledge
//   wbs_dat_o[31:0]       read data, valid with ack
//   Modports: master (host side), slave (scheduler side).
interface neuron_spike_scheduler_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/spike_word_packer.sv
// spike_word_packer
//   Packs a serial spike stream (neuron 0 first) into 32-bit words. Bit n of
//   the timestep lands in word n/32, bit n%32. A write strobe with the word
//   index and data is registered on the cycle after the 32nd bit of a word.
//   Ports:
//     clk, rst_n      clock, synchronous active-low reset
//     clr             synchronous clear (also drops a pending write)
//     bit_valid       a spike bit is accepted this cycle
//     bit_in          the accepted spike bit
//     wr_en           one-cycle buffer write strobe
//     wr_addr[AW-1:0] buffer word index
//     wr_data[31:0]   packed word
//     full            all NUM_NEURONS bits of the timestep accepted
//     last_wr         write strobe for the final word of the timestep
module spike_word_packer
  import neuron_spike_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 256,
  parameter int unsigned AW          = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [WORD_BITS-1:0] wr_data,
  output logic                 full,
  output logic                 last_wr
);

  localparam int unsigned CW        = $clog2(NUM_NEURONS) + 1;
  localparam int unsigned NUM_WORDS = words_for(NUM_NEURONS);

  logic [CW-1:0]        bit_cnt;
  logic [WORD_BITS-1:0] shreg;

  // Right shift: the first bit of a word ends up in bit 0 after 32 shifts.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      bit_cnt <= '0;
      shreg   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      if (bit_valid && !full) begin
        shreg   <= {bit_in, shreg[WORD_BITS-1:1]};
        bit_cnt <= bit_cnt + CW'(1);
        if (bit_cnt[4:0] == 5'd31) begin
          wr_en   <= 1'b1;
          wr_addr <= AW'(bit_cnt >> 5);
          wr_data <= {bit_in, shreg[WORD_BITS-1:1]};
        end
      end
    end
  end

  assign full    = (bit_cnt == CW'(NUM_NEURONS));
  assign last_wr = wr_en && (wr_addr == AW'(NUM_WORDS - 1));

endmodule

// File: rtl/neuron_spike_scheduler.sv
// neuron_spike_scheduler
//   Timestep sequencer for the neuron core spike output path. The host starts
//   a run through a 5-register Wishbone window; each timestep pulses the core,
//   packs its serial spike stream into 32-bit words and writes them into the
//   spike-out buffer. Completion is flagged in STATUS.done and on irq_o.
//   Optional feature macro: SPIKE_COUNT_EN (per-step spike counter at 0x10).
//   Ports:
//     wb_clk_i, wb_rst_n_i   clock, synchronous active-low reset
//     wbs                    Wishbone slave bundle (neuron_spike_scheduler_if)
//     step_start_o           one-cycle pulse, core begins a timestep
//     spike_valid_i/spike_i  serial spike stream from the core
//     spike_ready_o          spike bit accepted when valid & ready
//     spike_wr_en_o/addr/data  buffer write port
//     irq_o                  STATUS.done & CTRL.irq_en
module neuron_spike_scheduler
  import neuron_spike_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_3000,
  parameter int unsigned NUM_NEURONS = 256
) (
  input  logic                                        wb_clk_i,
  input  logic                                        wb_rst_n_i,
  neuron_spike_scheduler_if.slave                     wbs,
  output logic                                        step_start_o,
  input  logic                                        spike_valid_i,
  input  logic                                        spike_i,
  output logic                                        spike_ready_o,
  output logic                                        spike_wr_en_o,
  output logic [$clog2(NUM_NEURONS/WORD_BITS)-1:0]    spike_wr_addr_o,
  output logic [31:0]                                 spike_wr_data_o,
  output logic                                        irq_o
);

  localparam int unsigned NUM_WORDS = words_for(NUM_NEURONS);
  localparam int unsigned AW        = $clog2(NUM_WORDS);

  state_e      state, state_nx;
  logic        ctrl_auto, ctrl_irq_en, stat_done, ack_q;
  logic [15:0] target, done_cnt;
  logic [31:0] dat_q, rd_data, spike_cnt_rd;
  logic        pk_clr, pk_full, pk_last_wr, cnt_inc, done_set, keep_going;

  // Window is 256 bytes; offsets past the five registers ack and read 0.
  logic       in_win, req, bus_wr, ctrl_wr, start_req, abort_req, start_accept;
  logic [5:0] off;
  logic       unused_bus;

  assign off       = wbs.wbs_adr_i[7:2];
  assign in_win    = (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign req       = wbs.wbs_cyc_i && wbs.wbs_stb_i && in_win && !ack_q;
  assign bus_wr    = req && wbs.wbs_we_i;
  assign ctrl_wr   = bus_wr && (off == OFF_CTRL) && wbs.wbs_sel_i[0];
  assign start_req = ctrl_wr && wbs.wbs_dat_i[CTRL_START];
  assign abort_req = ctrl_wr && wbs.wbs_dat_i[CTRL_ABORT];
  assign start_accept = (state == S_IDLE) && start_req && !abort_req;
  assign unused_bus = ^{wbs.wbs_adr_i[1:0], wbs.wbs_dat_i[31:16], wbs.wbs_sel_i[3:2]};

  assign keep_going = ctrl_auto &&
                      ((target == 16'd0) || (({1'b0, done_cnt} + 17'd1) < {1'b0, target}));

  // FSM: state register
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) state <= S_IDLE;
    else             state <= state_nx;
  end

  // FSM: next state (abort overrides every transition)
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (start_req) state_nx = S_START;
      S_START:   state_nx = S_COLLECT;
      S_COLLECT: if (pk_last_wr) state_nx = S_DONE;
      S_DONE:    state_nx = keep_going ? S_START : S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
    if (abort_req) state_nx = S_IDLE;
  end

  // FSM: outputs
  always_comb begin
    step_start_o  = 1'b0;
    spike_ready_o = 1'b0;
    pk_clr        = abort_req;
    cnt_inc       = 1'b0;
    done_set      = 1'b0;
    unique case (state)
      S_START: begin
        step_start_o = 1'b1;
        pk_clr       = 1'b1;
      end
      S_COLLECT: spike_ready_o = !pk_full;
      S_DONE: begin
        cnt_inc  = !abort_req;
        done_set = !abort_req && !keep_going;
      end
      default: ;
    endcase
  end

  spike_word_packer #(
    .NUM_NEURONS (NUM_NEURONS),
    .AW          (AW)
  ) u_packer (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_n_i),
    .clr       (pk_clr),
    .bit_valid (spike_valid_i && spike_ready_o),
    .bit_in    (spike_i),
    .wr_en     (spike_wr_en_o),
    .wr_addr   (spike_wr_addr_o),
    .wr_data   (spike_wr_data_o),
    .full      (pk_full),
    .last_wr   (pk_last_wr)
  );

`ifdef SPIKE_COUNT_EN
  localparam int unsigned SCW = $clog2(NUM_NEURONS) + 1;
  logic [SCW-1:0] spike_acc, spike_cnt;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      spike_acc <= '0;
      spike_cnt <= '0;
    end else begin
      if (state == S_START)
        spike_acc <= '0;
      else if (spike_valid_i && spike_ready_o && spike_i)
        spike_acc <= spike_acc + SCW'(1);
      if ((state == S_DONE) && !abort_req)
        spike_cnt <= spike_acc;
    end
  end

  assign spike_cnt_rd = 32'(spike_cnt);
`else
  assign spike_cnt_rd = '0;
`endif

  always_comb begin
    rd_data = '0;
    unique case (off)
      OFF_CTRL: begin
        rd_data[CTRL_AUTO]   = ctrl_auto;
        rd_data[CTRL_IRQ_EN] = ctrl_irq_en;
      end
      OFF_STATUS: begin
        rd_data[STAT_BUSY] = (state != S_IDLE);
        rd_data[STAT_DONE] = stat_done;
      end
      OFF_TARGET:    rd_data = {16'd0, target};
      OFF_DONE_CNT:  rd_data = {16'd0, done_cnt};
      OFF_SPIKE_CNT: rd_data = spike_cnt_rd;
      default:       rd_data = '0;
    endcase
  end

  // The FSM reads ctrl_auto before this edge's write lands, so a CTRL write
  // coinciding with DONE only affects the next decision.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      ack_q       <= 1'b0;
      dat_q       <= '0;
      ctrl_auto   <= 1'b0;
      ctrl_irq_en <= 1'b0;
      target      <= '0;
      done_cnt    <= '0;
      stat_done   <= 1'b0;
    end else begin
      ack_q <= req;
      dat_q <= (req && !wbs.wbs_we_i) ? rd_data : '0;
      if (ctrl_wr) begin
        ctrl_auto   <= wbs.wbs_dat_i[CTRL_AUTO];
        ctrl_irq_en <= wbs.wbs_dat_i[CTRL_IRQ_EN];
      end
      if (bus_wr && (off == OFF_TARGET)) begin
        if (wbs.wbs_sel_i[0]) target[7:0]  <= wbs.wbs_dat_i[7:0];
        if (wbs.wbs_sel_i[1]) target[15:8] <= wbs.wbs_dat_i[15:8];
      end
      if (start_accept)
        done_cnt <= '0;
      else if (cnt_inc && (done_cnt != '1))
        done_cnt <= done_cnt + 16'd1;
      if (done_set)
        stat_done <= 1'b1;
      else if (bus_wr && (off == OFF_STATUS) && wbs.wbs_sel_i[0] && wbs.wbs_dat_i[STAT_DONE])
        stat_done <= 1'b0;
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign irq_o         = stat_done && ctrl_irq_en;

endmodule

// File: tb/tb_neuron_spike_scheduler.sv
// tb_neuron_spike_scheduler
//   Directed bench for neuron_spike_scheduler: single step, auto run with
//   interrupt, backpressured stream, abort, bus window edges, all-ones step
//   and reset in the middle of a step. Expected words come from the spike
//   pattern functions below.
module tb_neuron_spike_scheduler;

  localparam logic [31:0] BASE = 32'h3000_3000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_STAT = BASE + 32'h04;
  localparam logic [31:0] A_TGT  = BASE + 32'h08;
  localparam logic [31:0] A_DCNT = BASE + 32'h0C;
  localparam logic [31:0] A_SCNT = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        step_start, spike_ready, wr_en, irq;
  logic        spike_valid = 1'b0;
  logic        spike = 1'b0;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;

  always #5 clk = ~clk;

  neuron_spike_scheduler_if bus ();

  neuron_spike_scheduler #(
    .BASE_ADDR   (BASE),
    .NUM_NEURONS (256)
  ) dut (
    .wb_clk_i        (clk),
    .wb_rst_n_i      (rst_n),
    .wbs             (bus),
    .step_start_o    (step_start),
    .spike_valid_i   (spike_valid),
    .spike_i         (spike),
    .spike_ready_o   (spike_ready),
    .spike_wr_en_o   (wr_en),
    .spike_wr_addr_o (wr_addr),
    .spike_wr_data_o (wr_data),
    .irq_o           (irq)
  );

  int errors = 0;
  int checks = 0;
  int ss_cnt = 0;
  int n_acc  = 0;
  logic [2:0]  wa_log[$];
  logic [31:0] wd_log[$];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic pat(input int mode, input int n);
    if (mode == 1) return 1'b1;
    return ((n % 256) % 3) == 0;
  endfunction

  function automatic logic [31:0] expw(input int mode, input int k);
    logic [31:0] w;
    for (int b = 0; b < 32; b++) w[b] = pat(mode, 32 * k + b);
    return w;
  endfunction

  // Monitor: buffer writes, step pulses, and write-not-before-32-bits
  always @(negedge clk) begin
    if (step_start) ss_cnt++;
    if (wr_en) begin
      wa_log.push_back(wr_addr);
      wd_log.push_back(wr_data);
      check_val("wr_after_bits", 32'(n_acc >= 32 * (int'(wr_addr) + 1)), 32'd1);
    end
  end

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         output logic [31:0] rd, output logic acked);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    acked = 1'b0;
    rd    = '0;
    for (int i = 0; i < 4 && !acked; i++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) begin
        acked = 1'b1;
        rd    = bus.wbs_dat_o;
      end
    end
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] rd;
    logic        ack;
    wb_xfer(1'b1, adr, dat, rd, ack);
    check_val("wr_ack", 32'(ack), 32'd1);
  endtask

  task automatic wb_rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] rd;
    logic        ack;
    wb_xfer(1'b0, adr, '0, rd, ack);
    check_val({tag, "_ack"}, 32'(ack), 32'd1);
    check_val(tag, rd, exp);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive `count` spike bits; called and returns just after a rising edge.
  task automatic stream(input int mode, input int count, input bit toggle);
    int got = 0;
    int cyc = 0;
    bit acc;
    while (got < count && cyc < 4000) begin
      spike_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
      spike       = pat(mode, n_acc);
      @(negedge clk);
      acc = spike_valid && spike_ready;
      @(posedge clk); #1;
      if (acc) begin
        got++;
        n_acc++;
      end
      cyc++;
    end
    spike_valid = 1'b0;
    spike       = 1'b0;
    if (got < count) check_val("stream_timeout", 32'(got), 32'(count));
  endtask

  task automatic check_words(input string tag, input int mode, input int n);
    check_val({tag, "_nwr"}, 32'(wa_log.size()), 32'(n));
    for (int k = 0; k < n && k < wa_log.size(); k++) begin
      check_val({tag, "_addr"}, 32'(wa_log[k]), 32'(k % 8));
      check_val({tag, "_data"}, wd_log[k], expw(mode, k % 8));
    end
  endtask

  task automatic new_test();
    wa_log.delete();
    wd_log.delete();
    n_acc = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int ss0;
    logic [31:0] rd;
    logic        ack;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = '0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ctl_outs", 32'({step_start, spike_ready, wr_en, irq, bus.wbs_ack_o}), 32'd0);
    check_val("rst_wr_addr", 32'(wr_addr), 32'd0);
    check_val("rst_wr_data", wr_data, 32'd0);
    rst_n = 1'b1;
    settle(1);
    wb_rd_chk("rst_ctrl", A_CTRL, 32'd0);
    wb_rd_chk("rst_status", A_STAT, 32'd0);
    wb_rd_chk("rst_target", A_TGT, 32'd0);
    wb_rd_chk("rst_donecnt", A_DCNT, 32'd0);

    // 1: single step, neuron n spikes iff n%3==0
    new_test();
    ss0 = ss_cnt;
    wb_wr(A_TGT, 32'd0);
    wb_wr(A_CTRL, 32'h1);
    stream(0, 256, 1'b0);
    settle(6);
    check_words("t1", 0, 8);
    if (wd_log.size() > 0) check_val("t1_word0", wd_log[0], 32'h4924_9249);
    check_val("t1_steps", 32'(ss_cnt - ss0), 32'd1);
    wb_rd_chk("t1_status", A_STAT, 32'h2);
    wb_rd_chk("t1_donecnt", A_DCNT, 32'd1);

    // 2: auto run of 3 steps with interrupt
    wb_wr(A_STAT, 32'h2);
    new_test();
    ss0 = ss_cnt;
    wb_wr(A_TGT, 32'd3);
    wb_wr(A_CTRL, 32'h7);
    check_val("t2_irq_low", 32'(irq), 32'd0);
    stream(0, 768, 1'b0);
    settle(6);
    check_val("t2_steps", 32'(ss_cnt - ss0), 32'd3);
    check_words("t2", 0, 24);
    check_val("t2_irq_high", 32'(irq), 32'd1);
    wb_rd_chk("t2_donecnt", A_DCNT, 32'd3);
    wb_rd_chk("t2_status", A_STAT, 32'h2);
    wb_wr(A_STAT, 32'h2);
    check_val("t2_irq_cleared", 32'(irq), 32'd0);
    wb_wr(A_CTRL, 32'h0);

    // 3: backpressure, valid toggling every cycle
    new_test();
    wb_wr(A_CTRL, 32'h1);
    stream(0, 256, 1'b1);
    settle(6);
    check_words("t3", 0, 8);
    wb_rd_chk("t3_status", A_STAT, 32'h2);
    wb_wr(A_STAT, 32'h2);

    // 4: abort after 40 bits
    new_test();
    wb_wr(A_CTRL, 32'h1);
    stream(0, 40, 1'b0);
    wb_wr(A_CTRL, 32'h8);
    check_val("t4_ready_off", 32'(spike_ready), 32'd0);
    spike_valid = 1'b1;
    settle(40);
    spike_valid = 1'b0;
    check_words("t4", 0, 1);
    wb_rd_chk("t4_status", A_STAT, 32'h0);
    wb_rd_chk("t4_donecnt", A_DCNT, 32'd0);

    // 5: bus edges
    wb_rd_chk("t5_unmapped", BASE + 32'h14, 32'd0);
    wb_xfer(1'b0, BASE + 32'h100, '0, rd, ack);
    check_val("t5_outside_ack", 32'(ack), 32'd0);
    new_test();
    ss0 = ss_cnt;
    wb_wr(A_CTRL, 32'h1);
    stream(0, 50, 1'b0);
    wb_wr(A_CTRL, 32'h1);
    stream(0, 206, 1'b0);
    settle(6);
    check_val("t5_busy_start", 32'(ss_cnt - ss0), 32'd1);
    check_words("t5", 0, 8);
    wb_rd_chk("t5_donecnt", A_DCNT, 32'd1);
    wb_wr(A_STAT, 32'h2);
    ss0 = ss_cnt;
    wb_wr(A_CTRL, 32'h9);
    settle(3);
    check_val("t5_start_abort", 32'(ss_cnt - ss0), 32'd0);
    wb_rd_chk("t5_sa_status", A_STAT, 32'h0);

    // 6: all-ones step, then reset mid-collect
    new_test();
    wb_wr(A_CTRL, 32'h1);
    stream(1, 256, 1'b0);
    settle(6);
    check_words("t6", 1, 8);
`ifdef SPIKE_COUNT_EN
    wb_rd_chk("t6_spikecnt", A_SCNT, 32'd256);
`else
    wb_rd_chk("t6_spikecnt", A_SCNT, 32'd0);
`endif
    wb_wr(A_CTRL, 32'h1);
    stream(1, 20, 1'b0);
    rst_n = 1'b0;
    settle(1);
    check_val("t6_rst_ctl_outs", 32'({step_start, spike_ready, wr_en, irq, bus.wbs_ack_o}), 32'd0);
    check_val("t6_rst_wr_addr", 32'(wr_addr), 32'd0);
    check_val("t6_rst_wr_data", wr_data, 32'd0);
    check_val("t6_rst_dat_o", bus.wbs_dat_o, 32'd0);
    rst_n = 1'b1;
    settle(1);
    wb_rd_chk("t6_rst_status", A_STAT, 32'h0);
    wb_rd_chk("t6_rst_donecnt", A_DCNT, 32'd0);
    wb_rd_chk("t6_rst_spikecnt", A_SCNT, 32'd0);
    check_val("t6_no_extra_wr", 32'(wa_log.size()), 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
